// File: rtl/fir_coeff_loader.sv
// Coefficient writer for the fir block: builds a frame in a shadow bank, then commits all taps in one edge.
// Optional build macro COEFF_LOADER_SYMMETRIC_EN: each word fills a mirrored tap pair (linear-phase filters).
module fir_coeff_loader #(
    parameter int BITWIDTH = 16,
    parameter int N        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [BITWIDTH-1:0] in_data,
    input  logic                       in_last,
    output logic signed [BITWIDTH-1:0] coeffs [N-1:0],
    output logic                       loaded,
    output logic                       err
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
`ifdef COEFF_LOADER_SYMMETRIC_EN
    localparam int M = (N + 1) / 2;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
`else
    localparam int M = N;
`endif
    localparam logic [CW-1:0] M_C = CW'(M);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, COMMIT} state_t;

    state_t                      state, state_nxt;
    logic [CW-1:0]               cnt, cnt_nxt, base;
    logic [IW-1:0]               wr_idx;
    logic                        xfer, wr_en, err_set, loaded_set;
    logic signed [BITWIDTH-1:0]  shadow [N-1:0];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        wr_en      = 1'b0;
        err_set    = 1'b0;
        loaded_set = 1'b0;
        in_ready   = !rst && (state != COMMIT);
        // IDLE behaves like LOAD with an empty frame, so both share one path.
        base       = (state == IDLE) ? '0 : cnt;
        wr_idx     = base[IW-1:0];
        xfer       = in_valid && in_ready;
        case (state)
            IDLE, LOAD: begin
                if (xfer) begin
                    wr_en   = 1'b1;
                    cnt_nxt = base + ONE;
                    if (in_last) begin
                        if (cnt_nxt == M_C) begin
                            state_nxt = COMMIT;
                        end else begin
                            err_set   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else if (cnt_nxt == M_C) begin
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            DRAIN: begin
                if (xfer && in_last) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            COMMIT: begin
                loaded_set = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            loaded <= 1'b0;
            err    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                shadow[i] <= '0;
                coeffs[i] <= '0;
            end
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            loaded <= loaded_set;
            err    <= err_set;
            if (wr_en) begin
                shadow[wr_idx] <= in_data;
`ifdef COEFF_LOADER_SYMMETRIC_EN
                shadow[LAST_IDX - wr_idx] <= in_data;
`endif
            end
            // Whole bank swaps in one edge so fir never sees a mixed set.
            if (state == COMMIT) begin
                coeffs <= shadow;
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized bench for fir_coeff_loader: a frame-level model predicts in_ready, loaded, err and coeffs every cycle.
// Build with or without COEFF_LOADER_SYMMETRIC_EN to match the DUT.
module tb_fir_coeff_loader;

    localparam int BW = 16;
    localparam int N  = 16;
`ifdef COEFF_LOADER_SYMMETRIC_EN
    localparam int M = (N + 1) / 2;
`else
    localparam int M = N;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [BW-1:0] in_data = '0;
    logic                 in_last = 1'b0;
    logic signed [BW-1:0] coeffs [N-1:0];
    logic                 loaded;
    logic                 err;

    fir_coeff_loader #(.BITWIDTH(BW), .N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .coeffs(coeffs),
        .loaded(loaded), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: words of the open frame, the bank awaiting commit, and the visible bank.
    logic signed [BW-1:0] frame [$];
    logic signed [BW-1:0] pend_bank [N];
    logic signed [BW-1:0] exp_coeffs [N];
    bit commit_pend = 0;
    bit exp_loaded  = 0;
    bit exp_err     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive after negedge, predict, check outputs at the next negedge.
    task automatic step(input bit v, input logic signed [BW-1:0] d, input bit l, input bit r,
                        output bit accepted);
        bit exp_ready;
        in_valid = v; in_data = d; in_last = l; rst = r;
        #1;
        exp_ready = !r && !commit_pend;
        check("in_ready", in_ready, exp_ready);
        accepted = v && exp_ready;
        @(posedge clk);
        exp_loaded = 0;
        exp_err    = 0;
        if (r) begin
            frame.delete();
            commit_pend = 0;
            for (int i = 0; i < N; i++) exp_coeffs[i] = '0;
        end else begin
            if (commit_pend) begin
                exp_coeffs  = pend_bank;
                exp_loaded  = 1;
                commit_pend = 0;
            end
            if (accepted) begin
                frame.push_back(d);
                if (l) begin
                    if (frame.size() == M) begin
                        for (int k = 0; k < M; k++) begin
                            pend_bank[k] = frame[k];
`ifdef COEFF_LOADER_SYMMETRIC_EN
                            pend_bank[N-1-k] = frame[k];
`endif
                        end
                        commit_pend = 1;
                    end else begin
                        exp_err = 1;
                    end
                    frame.delete();
                end
            end
        end
        @(negedge clk);
        check("loaded", loaded, exp_loaded);
        check("err", err, exp_err);
        check("loaded_err_excl", loaded && err, 1'b0);
        for (int i = 0; i < N; i++)
            check($sformatf("coeffs[%0d]", i), coeffs[i], exp_coeffs[i]);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, BW'($urandom), 0, 0, a);
    endtask

    task automatic do_reset(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, '0, 0, 1, a);
    endtask

    task automatic send_word(input logic signed [BW-1:0] d, input bit l, input bit gaps);
        bit a;
        int guard;
        guard = 0;
        a = 0;
        while (!a) begin
            if (gaps && $urandom_range(1) == 0) step(0, BW'($urandom), 0, 0, a);
            else step(1, d, l, 0, a);
            guard++;
            if (guard > 64 && !a) begin
                check("word_accept_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic send_seq(input int len, input int start, input bit gaps);
        for (int k = 0; k < len; k++) send_word(BW'(start + k), k == len - 1, gaps);
    endtask

    task automatic check_ramp(input string tag);
        int e;
        for (int i = 0; i < N; i++) begin
`ifdef COEFF_LOADER_SYMMETRIC_EN
            e = ((i < N - 1 - i) ? i : N - 1 - i) + 1;
`else
            e = i + 1;
`endif
            check(tag, coeffs[i], BW'(e));
        end
    endtask

    initial begin
        int len;
        @(negedge clk);
        // Reset: outputs cleared, not ready while held.
        do_reset(2);
        idle(1);

        // Full valid frame 1..M, then the explicit ramp check.
        send_seq(M, 1, 0);
        idle(3);
        check_ramp("ramp_commit");

        // Short frame is rejected and leaves coeffs alone.
        send_seq(5, -5, 0);
        idle(2);
        check_ramp("ramp_after_short");

        // Over-long frame drains and is rejected.
        send_seq(20, 100, 0);
        idle(2);
        check_ramp("ramp_after_long");

        // Reset mid-frame, then an extreme-value frame.
        send_word(7, 0, 0);
        send_word(8, 0, 0);
        send_word(9, 0, 0);
        do_reset(1);
        send_word(16'sh7FFF, 0, 0);
        send_word(16'sh8000, M == 2, 0);
        for (int k = 2; k < M; k++) send_word(BW'($urandom), k == M - 1, 0);
        idle(2);

        // Same ramp with random idle gaps.
        send_seq(M, 1, 1);
        idle(3);
        check_ramp("ramp_gaps");

        // Back-to-back frames with no idle between them.
        send_seq(M, 50, 0);
        send_seq(M, 200, 0);
        idle(2);

        // Random frames of assorted lengths, data and gaps.
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(4))
                0: len = 1;
                1: len = M - 1;
                2: len = M + 1 + int'($urandom_range(3));
                default: len = M;
            endcase
            if (len < 1) len = 1;
            for (int k = 0; k < len; k++) send_word(BW'($urandom), k == len - 1, $urandom_range(1) == 1);
            if ($urandom_range(3) == 0) idle(int'($urandom_range(3)));
            if ($urandom_range(15) == 0) do_reset(1);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
